// File: rtl/data_mem_mmio_pkg.sv
// Shared definitions for the PMIPS data-memory stage: MMIO register addresses,
// STATUS bit positions and the address decoder used by the read mux and write strobes.
package data_mem_mmio_pkg;

    localparam logic [15:0] MMIO_LED    = 16'hFF00;
    localparam logic [15:0] MMIO_SW     = 16'hFF02;
    localparam logic [15:0] MMIO_TIMER  = 16'hFF04;
    localparam logic [15:0] MMIO_TX     = 16'hFF06;
    localparam logic [15:0] MMIO_STATUS = 16'hFF08;

    localparam int ST_FULL     = 0;
    localparam int ST_EMPTY    = 1;
    localparam int ST_OVERFLOW = 2;
    localparam int ST_MISALIGN = 3;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_LED,
        REG_SW,
        REG_TIMER,
        REG_TX,
        REG_STATUS,
        REG_NONE
    } region_e;

    // Byte address bit 0 is ignored so a misaligned access hits the enclosing word.
    function automatic region_e decode_region(input logic [15:0] addr, input int ram_bytes_log2);
        logic [15:0] word_addr;
        word_addr = {addr[15:1], 1'b0};
        if ((addr >> ram_bytes_log2) == 16'd0) return REG_RAM;
        case (word_addr)
            MMIO_LED:    return REG_LED;
            MMIO_SW:     return REG_SW;
            MMIO_TIMER:  return REG_TIMER;
            MMIO_TX:     return REG_TX;
            MMIO_STATUS: return REG_STATUS;
            default:     return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_mmio_if.sv
// Core-side data-memory bus plus the TX byte stream toward the serial/display block.
interface data_mem_mmio_if;
    logic [15:0] dmemaddr;
    logic [15:0] dmemwdata;
    logic        dmemwrite;
    logic        dmemread;
    logic [15:0] dmemrdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output dmemaddr, dmemwdata, dmemwrite, dmemread, tx_ready,
        input  dmemrdata, tx_data, tx_valid
    );

    modport slave (
        input  dmemaddr, dmemwdata, dmemwrite, dmemread, tx_ready,
        output dmemrdata, tx_data, tx_valid
    );
endinterface

// File: rtl/data_mem_mmio_sync_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is accepted only when a pop
// frees the head slot in the same cycle.
module sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    // NOTE: storage carries no reset; validity is tracked by count, so clearing it would only cost flops.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/data_mem_mmio.sv
// PMIPS data-memory stage: word RAM with zero-latency reads plus LED, switch,
// timer, TX-FIFO and STATUS registers mapped at the top of the address space.
module data_mem_mmio
    import data_mem_mmio_pkg::*;
#(
    parameter int ADDR_W     = 7,
    parameter int TIMER_DIV  = 50000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    data_mem_mmio_if.slave        bus,
    input  logic [7:0]            switches,
    output logic [7:0]            leds
);

    localparam int PRESC_W = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

    region_e             region;
    logic                wr_ram, wr_led, wr_timer, wr_tx, wr_status;
    logic [ADDR_W-1:0]   ram_idx;
    logic [15:0]         ram [2**ADDR_W];
    logic [7:0]          sw_meta, sw_sync;
    logic [PRESC_W-1:0]  prescaler;
    logic [15:0]         timer;
    logic                tick;
    logic                fifo_full, fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic [2:0]          count_disp;
    logic                overflow, misalign;
    logic                overflow_set, misalign_set;
    logic [15:0]         status_word;

    assign region    = decode_region(bus.dmemaddr, ADDR_W + 1);
    assign ram_idx   = bus.dmemaddr[ADDR_W:1];
    assign wr_ram    = bus.dmemwrite && (region == REG_RAM);
    assign wr_led    = bus.dmemwrite && (region == REG_LED);
    assign wr_timer  = bus.dmemwrite && (region == REG_TIMER);
    assign wr_tx     = bus.dmemwrite && (region == REG_TX);
    assign wr_status = bus.dmemwrite && (region == REG_STATUS);

    always_ff @(posedge clock) begin
        if (wr_ram) ram[ram_idx] <= bus.dmemwdata;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) leds <= '0;
        else if (wr_led) leds <= bus.dmemwdata[7:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= switches;
            sw_sync <= sw_meta;
        end
    end

    // A software clear outranks a tick landing on the same edge.
    assign tick = (prescaler == PRESC_W'(TIMER_DIV - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            timer     <= '0;
        end else if (wr_timer) begin
            prescaler <= '0;
            timer     <= '0;
        end else if (tick) begin
            prescaler <= '0;
            timer     <= timer + 16'd1;
        end else begin
            prescaler <= prescaler + PRESC_W'(1);
        end
    end

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (wr_tx),
        .pop   (bus.tx_ready),
        .din   (bus.dmemwdata[7:0]),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .head  (bus.tx_data)
    );

    assign bus.tx_valid = !fifo_empty;

    // A full FIFO only drops the byte when no pop frees a slot this cycle.
    assign overflow_set = wr_tx && fifo_full && !bus.tx_ready;
    assign misalign_set = (bus.dmemread || bus.dmemwrite) && bus.dmemaddr[0] && (region != REG_NONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
            misalign <= 1'b0;
        end else begin
            overflow <= overflow_set || (overflow && !(wr_status && bus.dmemwdata[ST_OVERFLOW]));
            misalign <= misalign_set || (misalign && !(wr_status && bus.dmemwdata[ST_MISALIGN]));
        end
    end

    assign count_disp  = (32'(fifo_count) > 32'd7) ? 3'd7 : 3'(fifo_count);
    assign status_word = {9'b0, count_disp, misalign, overflow, fifo_empty, fifo_full};

    // NOTE: the default assignment first keeps every path driven, so no latch is inferred.
    always_comb begin
        bus.dmemrdata = 16'h0000;
        if (bus.dmemread && !reset) begin
            case (region)
                REG_RAM:    bus.dmemrdata = ram[ram_idx];
                REG_LED:    bus.dmemrdata = {8'h00, leds};
                REG_SW:     bus.dmemrdata = {8'h00, sw_sync};
                REG_TIMER:  bus.dmemrdata = timer;
                REG_STATUS: bus.dmemrdata = status_word;
                default:    bus.dmemrdata = 16'h0000;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Scoreboarded bench for data_mem_mmio: directed scenarios plus randomized traffic
// checked against a behavioural memory/MMIO model.
module tb_data_mem_mmio;

    localparam int DIV   = 3;
    localparam int DEPTH = 4;
    localparam int WORDS = 128;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] switches = 8'h00;
    logic [7:0] leds;

    data_mem_mmio_if bus();

    data_mem_mmio #(.ADDR_W(7), .TIMER_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .switches (switches),
        .leds     (leds)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    logic [15:0] rd_q [$];
    logic [7:0]  tx_q [$];

    logic [15:0] m_ram [WORDS];
    logic [7:0]  m_leds, m_sw1, m_sw2;
    logic [15:0] m_timer;
    int          m_presc, m_cnt;
    bit          m_ovf, m_mis;

    typedef enum {R_RAM, R_LED, R_SW, R_TIM, R_TX, R_ST, R_NONE} reg_t;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic reg_t region_of(input logic [15:0] a);
        if (a < 16'd256) return R_RAM;
        case (a & 16'hFFFE)
            16'hFF00: return R_LED;
            16'hFF02: return R_SW;
            16'hFF04: return R_TIM;
            16'hFF06: return R_TX;
            16'hFF08: return R_ST;
            default:  return R_NONE;
        endcase
    endfunction

    function automatic logic [15:0] model_read(input logic [15:0] a);
        int c, v;
        c = (m_cnt > 7) ? 7 : m_cnt;
        case (region_of(a))
            R_RAM: return m_ram[a[7:1]];
            R_LED: return {8'h00, m_leds};
            R_SW:  return {8'h00, m_sw2};
            R_TIM: return m_timer;
            R_ST: begin
                v = c * 16 + (m_mis ? 8 : 0) + (m_ovf ? 4 : 0)
                  + ((m_cnt == 0) ? 2 : 0) + ((m_cnt == DEPTH) ? 1 : 0);
                return 16'(v);
            end
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_edge(input logic [15:0] a, input logic [15:0] wd, input bit we,
                              input bit re, input bit rdy, input logic [7:0] sw);
        reg_t r;
        bit pop, push, acc, clr_st;
        r      = region_of(a);
        pop    = rdy && (m_cnt > 0);
        push   = we && (r == R_TX);
        acc    = push && ((m_cnt < DEPTH) || pop);
        clr_st = we && (r == R_ST);
        if (we && r == R_RAM) m_ram[a[7:1]] = wd;
        if (we && r == R_LED) m_leds = wd[7:0];
        if (we && r == R_TIM) begin
            m_timer = 16'h0; m_presc = 0;
        end else if (m_presc == DIV - 1) begin
            m_presc = 0; m_timer = m_timer + 16'h1;
        end else begin
            m_presc++;
        end
        if (acc) tx_q.push_back(wd[7:0]);
        m_cnt = m_cnt + (acc ? 1 : 0) - (pop ? 1 : 0);
        m_ovf = (push && !acc) || (m_ovf && !(clr_st && wd[2]));
        m_mis = ((we || re) && a[0] && r != R_NONE) || (m_mis && !(clr_st && wd[3]));
        m_sw2 = m_sw1;
        m_sw1 = sw;
    endtask

    // One bus cycle: drive after the previous edge, log expectations, let the edge happen.
    task automatic cycle(input logic [15:0] a, input logic [15:0] wd, input bit we, input bit re,
                         input bit rdy, input bit use_exp = 1'b0, input logic [15:0] exp = 16'h0);
        bus.dmemaddr  = a;
        bus.dmemwdata = wd;
        bus.dmemwrite = we;
        bus.dmemread  = re;
        bus.tx_ready  = rdy;
        switches      = 8'($urandom);
        if (re) rd_q.push_back(use_exp ? exp : model_read(a));
        @(posedge clock);
        model_edge(a, wd, we, re, rdy, switches);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d, input bit rdy);
        cycle(a, d, 1'b1, 1'b0, rdy);
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] exp, input bit rdy);
        cycle(a, 16'h0, 1'b0, 1'b1, rdy, 1'b1, exp);
    endtask

    task automatic idle(input bit rdy);
        cycle(16'h0, 16'h0, 1'b0, 1'b0, rdy);
    endtask

    task automatic do_reset();
        bus.dmemwrite = 1'b0;
        bus.dmemread  = 1'b1;
        bus.dmemaddr  = 16'h0010;
        bus.tx_ready  = 1'b0;
        reset = 1'b1;
        #1;
        check("reset_leds", {8'h00, leds}, 16'h0000);
        check("reset_tx_valid", 16'(bus.tx_valid), 16'h0000);
        check("reset_tx_data", {8'h00, bus.tx_data}, 16'h0000);
        check("reset_rdata", bus.dmemrdata, 16'h0000);
        bus.dmemread = 1'b0;
        m_leds = 8'h00; m_sw1 = 8'h00; m_sw2 = 8'h00;
        m_timer = 16'h0; m_presc = 0; m_cnt = 0; m_ovf = 1'b0; m_mis = 1'b0;
        tx_q.delete();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (bus.dmemread) begin
                if (rd_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rdata_unexpected: got 0x%04h, no expectation queued", bus.dmemrdata);
                end else begin
                    check("rdata", bus.dmemrdata, rd_q.pop_front());
                end
            end else begin
                check("rdata_idle", bus.dmemrdata, 16'h0000);
            end
            check("leds", {8'h00, leds}, {8'h00, m_leds});
            check("tx_valid", 16'(bus.tx_valid), 16'(m_cnt != 0));
            if (bus.tx_valid && bus.tx_ready) begin
                if (tx_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL tx_unexpected: got 0x%02h, no byte expected", bus.tx_data);
                end else begin
                    check("tx_data", {8'h00, bus.tx_data}, {8'h00, tx_q.pop_front()});
                end
            end else if (!bus.tx_valid) begin
                check("tx_data_empty", {8'h00, bus.tx_data}, 16'h0000);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] a, wd;
        bit we, re, rdy;
        int op, rdy_pct;

        bus.dmemaddr = 16'h0; bus.dmemwdata = 16'h0;
        bus.dmemwrite = 1'b0; bus.dmemread = 1'b0; bus.tx_ready = 1'b0;
        #2;
        do_reset();
        for (int w = 0; w < WORDS; w++) wr(16'(w * 2), 16'($urandom), 1'b0);

        // Timer from a fresh reset, then a clear colliding with a tick.
        do_reset();
        repeat (9) idle(1'b0);
        rd(16'hFF04, 16'h0003, 1'b0);
        for (int k = 0; k < 8 && m_presc != DIV - 1; k++) idle(1'b0);
        wr(16'hFF04, 16'h1234, 1'b0);
        rd(16'hFF04, 16'h0000, 1'b0);

        wr(16'h0010, 16'h1234, 1'b0);
        rd(16'h0010, 16'h1234, 1'b0);
        idle(1'b0);

        wr(16'hFF00, 16'h00A5, 1'b0);
        check("leds_a5", {8'h00, leds}, 16'h00A5);
        rd(16'hFF00, 16'h00A5, 1'b0);

        for (int b = 0; b < 5; b++) wr(16'hFF06, 16'(16'h41 + b), 1'b0);
        rd(16'hFF08, 16'h0045, 1'b0);
        repeat (4) idle(1'b1);
        idle(1'b0);
        check("drained_valid", 16'(bus.tx_valid), 16'h0000);

        wr(16'hFF08, 16'h000C, 1'b0);
        for (int b = 0; b < 4; b++) wr(16'hFF06, 16'(16'h51 + b), 1'b0);
        wr(16'hFF06, 16'h0055, 1'b1);
        rd(16'hFF08, 16'h0041, 1'b0);
        repeat (4) idle(1'b1);
        idle(1'b0);
        check("drained_valid2", 16'(bus.tx_valid), 16'h0000);

        wr(16'h0010, 16'hBEEF, 1'b0);
        rd(16'h0011, 16'hBEEF, 1'b0);
        rd(16'hFF08, 16'h000A, 1'b0);
        rd(16'h8000, 16'h0000, 1'b0);
        wr(16'hFF08, 16'h0008, 1'b0);

        wr(16'hFF06, 16'h0066, 1'b0);
        wr(16'hFF06, 16'h0077, 1'b1);
        check("head_after_swap", {8'h00, bus.tx_data}, 16'h0077);
        idle(1'b1);

        for (int b = 0; b < 3; b++) wr(16'hFF06, 16'(16'h60 + b), 1'b0);
        wr(16'hFF00, 16'h003C, 1'b0);
        idle(1'b1);
        do_reset();

        for (int i = 0; i < 3000; i++) begin
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2, 3: a = 16'($urandom_range(0, WORDS - 1) * 2);
                4: a = 16'hFF00;
                5: a = 16'hFF02;
                6: a = 16'hFF04;
                7: a = 16'hFF06;
                8: a = 16'hFF08;
                default: a = 16'($urandom);
            endcase
            if ($urandom_range(0, 7) == 0) a[0] = 1'b1;
            wd = 16'($urandom);
            we = ($urandom_range(0, 1) == 1);
            re = ($urandom_range(0, 1) == 1);
            if (op == 6 && $urandom_range(0, 7) != 0) we = 1'b0;
            rdy_pct = ((i % 500) < 250) ? 20 : 70;
            rdy = ($urandom_range(0, 99) < rdy_pct);
            cycle(a, wd, we, re, rdy);
        end

        repeat (DEPTH + 2) idle(1'b1);
        idle(1'b0);
        check("rd_q_empty", 16'(rd_q.size()), 16'h0000);
        check("tx_q_empty", 16'(tx_q.size()), 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
